// File: rtl/blk2s_kdf_seq_pkg.sv
// ============================================================================
// blk2s_kdf_seq_pkg : shared types, defaults and byte-sum helper.   Rev 1.0
// ============================================================================
`default_nettype none

package blk2s_kdf_seq_pkg;

   localparam int C_DEF_ROUNDS      = 32;
   localparam int C_DEF_OUTPUT_SIZE = 32;
   localparam int C_DEF_RND_W       = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Sum of all bytes of a default-size PRF output, wrapping in 8 bits.
   function automatic logic [7:0] byte_sum(input logic [C_DEF_OUTPUT_SIZE*8-1:0] data);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < C_DEF_OUTPUT_SIZE; i++) begin
         acc = acc + data[8*i +: 8];
      end
      return acc;
   endfunction

endpackage

`default_nettype wire

// File: rtl/blk2s_kdf_seq_if.sv
// ============================================================================
// blk2s_kdf_seq_if : job / PRF / update / done bus of the round sequencer. Rev 1.0
// ============================================================================
`default_nettype none

interface blk2s_kdf_seq_if
   import blk2s_kdf_seq_pkg::*;
#(
   parameter int OUTPUT_SIZE = C_DEF_OUTPUT_SIZE,
   parameter int RND_W       = C_DEF_RND_W
);

   logic                     job_vld;
   logic                     job_rdy;
   logic [7:0]               job_ptr;

   logic                     prf_req_vld;
   logic                     prf_req_rdy;
   logic [7:0]               prf_ptr;
   logic [RND_W-1:0]         prf_round;

   logic                     prf_rsp_vld;
   logic                     prf_rsp_rdy;
   logic [OUTPUT_SIZE*8-1:0] prf_output;

   logic                     upd_vld;
   logic [7:0]               upd_ptr;
   logic [7:0]               upd_next_ptr;

   logic                     done_vld;
   logic                     done_rdy;
   logic [7:0]               done_ptr;

   logic                     busy;

   modport master (
      input  job_vld, job_ptr, prf_req_rdy, prf_rsp_vld, prf_output, done_rdy,
      output job_rdy, prf_req_vld, prf_ptr, prf_round, prf_rsp_rdy,
             upd_vld, upd_ptr, upd_next_ptr, done_vld, done_ptr, busy
   );

   modport slave (
      output job_vld, job_ptr, prf_req_rdy, prf_rsp_vld, prf_output, done_rdy,
      input  job_rdy, prf_req_vld, prf_ptr, prf_round, prf_rsp_rdy,
             upd_vld, upd_ptr, upd_next_ptr, done_vld, done_ptr, busy
   );

endinterface

`default_nettype wire

// File: rtl/blk2s_byte_sum.sv
// ============================================================================
// blk2s_byte_sum : combinational adder tree, N bytes -> 8-bit wrapping sum. Rev 1.0
// ============================================================================
`default_nettype none

module blk2s_byte_sum
   import blk2s_kdf_seq_pkg::*;
#(
   parameter int N_BYTES = C_DEF_OUTPUT_SIZE
) (
   input  logic [N_BYTES*8-1:0] data_i,
   output logic [7:0]           sum_o
);

   localparam int LVLS = $clog2(N_BYTES);
   localparam int NP   = 1 << LVLS;

   logic [NP*8-1:0] pad_w;
   logic [7:0]      lvl [NP];

   // Leaves are zero-padded to a power of two so every level pairs evenly.
   assign pad_w = (NP*8)'(data_i);

   always_comb begin
      for (int j = 0; j < NP; j++) begin
         lvl[j] = pad_w[8*j +: 8];
      end
      for (int l = 0; l < LVLS; l++) begin
         for (int i = 0; i < (NP >> (l + 1)); i++) begin
            lvl[i] = lvl[2*i] + lvl[2*i+1];
         end
      end
   end

   assign sum_o = lvl[0];

endmodule

`default_nettype wire

// File: rtl/blk2s_kdf_seq.sv
// ============================================================================
// blk2s_kdf_seq : FastKDF round sequencer around the BLAKE2s PRF core.  Rev 1.0
// ============================================================================
`default_nettype none

module blk2s_kdf_seq
   import blk2s_kdf_seq_pkg::*;
#(
   parameter int ROUNDS      = C_DEF_ROUNDS,
   parameter int OUTPUT_SIZE = C_DEF_OUTPUT_SIZE,
   parameter int RND_W       = C_DEF_RND_W
) (
   input  logic           clk,
   input  logic           rst_n,
   blk2s_kdf_seq_if.master bus
);

   localparam logic [RND_W-1:0] C_LAST_RND = RND_W'(ROUNDS - 1);

   state_t           state_q, state_d;
   logic [7:0]       ptr_q,   ptr_d;
   logic [7:0]       old_q,   old_d;
   logic [7:0]       nxt_q,   nxt_d;
   logic [RND_W-1:0] rnd_q,   rnd_d;
   logic [7:0]       sum_w;

   blk2s_byte_sum #(
      .N_BYTES (OUTPUT_SIZE)
   ) u_byte_sum (
      .data_i  (bus.prf_output),
      .sum_o   (sum_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 8'h00;
         old_q   <= 8'h00;
         nxt_q   <= 8'h00;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         old_q   <= old_d;
         nxt_q   <= nxt_d;
         rnd_q   <= rnd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      old_d   = old_q;
      nxt_d   = nxt_q;
      rnd_d   = rnd_q;

      bus.job_rdy     = 1'b0;
      bus.prf_req_vld = 1'b0;
      bus.prf_rsp_rdy = 1'b0;
      bus.upd_vld     = 1'b0;
      bus.done_vld    = 1'b0;
      bus.busy        = 1'b1;

      case (state_q)
         ST_IDLE: begin
            bus.job_rdy = 1'b1;
            bus.busy    = 1'b0;
            if (bus.job_vld) begin
               ptr_d   = bus.job_ptr;
               rnd_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.prf_req_vld = 1'b1;
            if (bus.prf_req_rdy) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            bus.prf_rsp_rdy = 1'b1;
            if (bus.prf_rsp_vld) begin
               nxt_d   = sum_w;
               old_d   = ptr_q;
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            bus.upd_vld = 1'b1;
            ptr_d       = nxt_q;
            rnd_d       = rnd_q + 1'b1;
            state_d     = (rnd_q == C_LAST_RND) ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: begin
            bus.done_vld = 1'b1;
            if (bus.done_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Data outputs come straight from registers so they stay stable while held.
   assign bus.prf_ptr      = ptr_q;
   assign bus.prf_round    = rnd_q;
   assign bus.upd_ptr      = old_q;
   assign bus.upd_next_ptr = nxt_q;
   assign bus.done_ptr     = ptr_q;

endmodule

`default_nettype wire
